// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to a handshaked memory, youngest-match load forwarding.
// Optional STBUF_COALESCE_EN: stores to an already buffered (not in-flight) address merge in place.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  entry_t        buf_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count, count_nxt;
  state_t        state, state_nxt;
  logic          push, pop, coal_hit;
  logic [PW-1:0] coal_idx;

  assign cpu_stall = (count == FULL);
  assign mem_req   = (state == REQ);
  assign mem_raddr = cpu_addr;
  assign mem_waddr = mem_req ? {buf_q[head].addr, 2'b00} : '0;
  assign mem_wdata = mem_req ? buf_q[head].data : '0;
  assign empty     = (count == '0) && !mem_req;

  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    cpu_rdata = mem_rdata;
    for (int a = 0; a < DEPTH; a++) begin
      logic [PW-1:0] fi;
      fi = head + PW'(a);
      if (((PW+1)'(a) < count) && (buf_q[fi].addr == cpu_addr[31:2]))
        cpu_rdata = buf_q[fi].data;
    end
  end

`ifdef STBUF_COALESCE_EN
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int a = 0; a < DEPTH; a++) begin
      logic [PW-1:0] ci;
      ci = head + PW'(a);
      // The in-flight head must not change under an active request.
      if (cpu_we && ((PW+1)'(a) < count) && !(a == 0 && state == REQ) &&
          (buf_q[ci].addr == cpu_addr[31:2])) begin
        coal_hit = 1'b1;
        coal_idx = ci;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  assign pop       = (state == REQ) && mem_ack;
  assign push      = cpu_we && !cpu_stall && !coal_hit;
  assign count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = REQ;
      REQ:     if (mem_ack && count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  // Entry storage needs no reset: only slots inside [head, head+count) are ever read.
  always_ff @(posedge clk) begin
    if (push)          buf_q[tail]          <= '{addr: cpu_addr[31:2], data: cpu_wdata};
    else if (coal_hit) buf_q[coal_idx].data <= cpu_wdata;
  end
endmodule
